// File: rtl/branch_predictor_pkg.sv
// bp_pkg: shared BTB types, counter encodings and PC field helpers
package bp_pkg;
    localparam int BP_INDEX_BITS = 4;
    localparam int BP_TAG_BITS   = 8;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_ctr_e;

    typedef struct packed {
        logic                   valid;
        logic [BP_TAG_BITS-1:0] tag;
        logic [31:0]            target;
        logic [1:0]             ctr;
    } bp_entry_t;

    localparam bp_entry_t BP_ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: BP_WNT};

    function automatic logic [BP_INDEX_BITS-1:0] bp_index(input logic [31:0] pc);
        return pc[BP_INDEX_BITS+1:2];
    endfunction

    function automatic logic [BP_TAG_BITS-1:0] bp_tag(input logic [31:0] pc);
        return pc[BP_INDEX_BITS+BP_TAG_BITS+1:BP_INDEX_BITS+2];
    endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup and decode resolve signals of the predictor
interface branch_predictor_if #(
    parameter int CNT_WIDTH = 16
);
    logic [31:0]          PCF;
    logic                 PredictTakenF;
    logic [31:0]          PredictedTargetF;
    logic                 StallD;
    logic                 FlushD;
    logic                 PredictionD;
    logic [31:0]          PCD;
    logic                 BranchD;
    logic                 BranchTakenD;
    logic [31:0]          BranchTargetD;
    logic                 MispredictD;
    logic [31:0]          RedirectPCD;
    logic [CNT_WIDTH-1:0] MispredictCount;

    modport master (
        output PCF, StallD, FlushD, PCD, BranchD, BranchTakenD, BranchTargetD,
        input  PredictTakenF, PredictedTargetF, PredictionD, MispredictD, RedirectPCD, MispredictCount
    );

    modport slave (
        input  PCF, StallD, FlushD, PCD, BranchD, BranchTakenD, BranchTargetD,
        output PredictTakenF, PredictedTargetF, PredictionD, MispredictD, RedirectPCD, MispredictCount
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating taken/not-taken counter
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);
    // step toward the resolved direction, sticking at the strong ends
    always_comb ctr_next = taken ? ((ctr == BP_ST) ? ctr : ctr + 2'd1)
                                 : ((ctr == BP_SNT) ? ctr : ctr - 2'd1);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB lookup in Fetch, training and recovery in Decode
module branch_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = BP_INDEX_BITS,
    parameter int TAG_BITS   = BP_TAG_BITS,
    parameter int CNT_WIDTH  = 16
) (
    input logic          clk,
    input logic          reset,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    // flop array so valid/ctr can be reset
    bp_entry_t btb_q [ENTRIES];
    bp_entry_t btb_d [ENTRIES];
    logic                  pred_q, pred_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [INDEX_BITS-1:0] f_idx, d_idx;
    logic [TAG_BITS-1:0]   f_tag, d_tag;
    bp_entry_t             f_e, d_e, upd_e;
    logic                  d_hit, resolve;
    logic [1:0]            ctr_next;

    assign f_idx = bp_index(bp.PCF);
    assign f_tag = bp_tag(bp.PCF);
    assign d_idx = bp_index(bp.PCD);
    assign d_tag = bp_tag(bp.PCD);
    assign f_e   = btb_q[f_idx];
    assign d_e   = btb_q[d_idx];
    assign d_hit = d_e.valid && (d_e.tag == d_tag);
    assign resolve = bp.BranchD && !bp.StallD;

    assign bp.PredictTakenF    = f_e.valid && (f_e.tag == f_tag) && f_e.ctr[1];
    assign bp.PredictedTargetF = bp.PredictTakenF ? f_e.target : 32'd0;
    assign bp.PredictionD      = pred_q;
    assign bp.MispredictD      = bp.BranchD && (bp.BranchTakenD ^ pred_q);
    assign bp.RedirectPCD      = bp.BranchTakenD ? bp.BranchTargetD : bp.PCD + 32'd4;
    assign bp.MispredictCount  = cnt_q;

    sat_counter2 u_ctr (
        .ctr      (d_e.ctr),
        .taken    (bp.BranchTakenD),
        .ctr_next (ctr_next)
    );

    // train a hit entry, or allocate on a taken miss; not-taken misses leave the table alone
    always_comb begin
        upd_e.valid  = 1'b1;
        upd_e.tag    = d_tag;
        upd_e.target = bp.BranchTakenD ? bp.BranchTargetD : d_e.target;
        upd_e.ctr    = d_hit ? ctr_next : BP_WT;
        btb_d        = btb_q;
        if (resolve && (d_hit || bp.BranchTakenD))
            btb_d[d_idx] = upd_e;
    end

    // F->D prediction pipe (flush beats stall) and saturating mispredict count
    always_comb begin
        pred_d = bp.FlushD ? 1'b0 : (bp.StallD ? pred_q : bp.PredictTakenF);
        cnt_d  = (resolve && bp.MispredictD && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    // state registers; reset drops any update pending in the same cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            btb_q  <= '{default: BP_ENTRY_RST};
            pred_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            btb_q  <= btb_d;
            pred_q <= pred_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table plus randomized model comparison
module tb_branch_predictor;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_predictor_if #(.CNT_WIDTH(16)) bp ();

    branch_predictor #(.INDEX_BITS(4), .TAG_BITS(8), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp)
    );

    typedef struct {
        logic        rst_n;
        logic [31:0] pcf;
        logic        stall, flush;
        logic [31:0] pcd;
        logic        br, tk;
        logic [31:0] tgt;
        logic        ptf;
        logic [31:0] ptgt;
        logic        predd, mis;
        logic [31:0] redir;
        int          cnt;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vq[$];

    // reference model state
    bit          m_valid [16];
    int          m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    bit          m_pred;
    int          m_cnt;

    function automatic vec_t mk(logic r, logic [31:0] pcf, logic st, logic fl, logic [31:0] pcd,
                                logic br, logic tk, logic [31:0] tgt, logic ptf, logic [31:0] ptgt,
                                logic pd, logic mis, logic [31:0] redir, int cnt);
        vec_t v;
        v.rst_n = r; v.pcf = pcf; v.stall = st; v.flush = fl; v.pcd = pcd; v.br = br; v.tk = tk;
        v.tgt = tgt; v.ptf = ptf; v.ptgt = ptgt; v.predd = pd; v.mis = mis; v.redir = redir; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        reset            = v.rst_n;
        bp.PCF           = v.pcf;
        bp.StallD        = v.stall;
        bp.FlushD        = v.flush;
        bp.PCD           = v.pcd;
        bp.BranchD       = v.br;
        bp.BranchTakenD  = v.tk;
        bp.BranchTargetD = v.tgt;
    endtask

    task automatic run_vec(string tag, vec_t v);
        drive(v);
        #2;
        chk({tag, " PredictTakenF"},    32'(bp.PredictTakenF),   32'(v.ptf));
        chk({tag, " PredictedTargetF"}, bp.PredictedTargetF,     v.ptgt);
        chk({tag, " PredictionD"},      32'(bp.PredictionD),     32'(v.predd));
        chk({tag, " MispredictD"},      32'(bp.MispredictD),     32'(v.mis));
        chk({tag, " RedirectPCD"},      bp.RedirectPCD,          v.redir);
        chk({tag, " MispredictCount"},  32'(bp.MispredictCount), 32'(v.cnt));
        @(posedge clk);
        #1;
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_pred = 0;
        m_cnt  = 0;
    endfunction

    function automatic logic [31:0] pick_pc();
        return 32'(($urandom_range(0, 1) << 20) | (($urandom_range(0, 2) + 4) << 6) | ($urandom_range(0, 3) << 2));
    endfunction

    initial begin
        vec_t v;
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        repeat (2) @(posedge clk);
        #1;

        //      rst pcf    st fl pcd    br tk tgt      ptf ptgt   pd mis redir  cnt
        vq.push_back(mk(1, 'h100, 0, 0, 'h000, 0, 0, 'h000, 0, 'h000, 0, 0, 'h004, 0)); // after reset
        vq.push_back(mk(1, 'h000, 0, 0, 'h100, 1, 1, 'h200, 0, 'h000, 0, 1, 'h200, 0)); // first taken
        vq.push_back(mk(1, 'h100, 0, 0, 'h100, 0, 0, 'h000, 1, 'h200, 0, 0, 'h104, 1));
        vq.push_back(mk(1, 'h100, 0, 0, 'h100, 1, 1, 'h200, 1, 'h200, 1, 0, 'h200, 1)); // ctr 11
        vq.push_back(mk(1, 'h100, 0, 0, 'h100, 1, 1, 'h200, 1, 'h200, 1, 0, 'h200, 1));
        vq.push_back(mk(1, 'h100, 0, 0, 'h100, 1, 1, 'h200, 1, 'h200, 1, 0, 'h200, 1));
        vq.push_back(mk(1, 'h100, 0, 0, 'h100, 1, 0, 'h000, 1, 'h200, 1, 1, 'h104, 1)); // -> 10
        vq.push_back(mk(1, 'h100, 0, 0, 'h100, 1, 0, 'h000, 1, 'h200, 1, 1, 'h104, 2)); // -> 01
        vq.push_back(mk(1, 'h100, 0, 0, 'h100, 0, 0, 'h000, 0, 'h000, 1, 0, 'h104, 3));
        vq.push_back(mk(1, 'h100, 0, 0, 'h100, 1, 1, 'h200, 0, 'h000, 0, 1, 'h200, 3)); // -> 10
        vq.push_back(mk(1, 'h140, 0, 0, 'h140, 1, 0, 'h000, 0, 'h000, 0, 0, 'h144, 4)); // alias NT
        vq.push_back(mk(1, 'h100, 0, 0, 'h000, 0, 0, 'h000, 1, 'h200, 0, 0, 'h004, 4));
        vq.push_back(mk(1, 'h140, 0, 0, 'h000, 0, 0, 'h000, 0, 'h000, 1, 0, 'h004, 4));
        vq.push_back(mk(1, 'h100, 1, 0, 'h100, 1, 1, 'h300, 1, 'h200, 0, 1, 'h300, 4)); // stalled
        vq.push_back(mk(1, 'h100, 1, 0, 'h100, 1, 1, 'h300, 1, 'h200, 0, 1, 'h300, 4));
        vq.push_back(mk(1, 'h100, 0, 0, 'h100, 1, 1, 'h300, 1, 'h200, 0, 1, 'h300, 4)); // released
        vq.push_back(mk(1, 'h100, 0, 0, 'h000, 0, 0, 'h000, 1, 'h300, 1, 0, 'h004, 5));
        vq.push_back(mk(1, 'h100, 1, 1, 'h000, 0, 0, 'h000, 1, 'h300, 1, 0, 'h004, 5)); // flush+stall
        vq.push_back(mk(1, 'h100, 0, 0, 'h000, 0, 0, 'h000, 1, 'h300, 0, 0, 'h004, 5));
        vq.push_back(mk(1, 'h100, 0, 0, 'h100, 1, 0, 'h000, 1, 'h300, 1, 1, 'h104, 5)); // -> 10
        vq.push_back(mk(1, 'h100, 0, 0, 'h100, 1, 0, 'h000, 1, 'h300, 1, 1, 'h104, 6)); // same-cycle old
        vq.push_back(mk(1, 'h100, 0, 0, 'h000, 0, 0, 'h000, 0, 'h000, 1, 0, 'h004, 7)); // new next cycle
        vq.push_back(mk(0, 'h100, 0, 0, 'h100, 1, 1, 'h400, 0, 'h000, 0, 1, 'h400, 7)); // reset w/ update
        vq.push_back(mk(1, 'h100, 0, 0, 'h000, 0, 0, 'h000, 0, 'h000, 0, 0, 'h004, 0));
        vq.push_back(mk(1, 'h100, 0, 0, 'h100, 1, 0, 'h000, 0, 'h000, 0, 0, 'h104, 0)); // miss NT
        vq.push_back(mk(1, 'h100, 0, 0, 'h100, 1, 1, 'h500, 0, 'h000, 0, 1, 'h500, 0)); // allocate
        vq.push_back(mk(1, 'h100, 0, 0, 'h000, 0, 0, 'h000, 1, 'h500, 0, 0, 'h004, 1));

        foreach (vq[i]) run_vec($sformatf("vec%0d", i), vq[i]);

        // aliasing PC allocates over the trained entry
        run_vec("alias_alloc", mk(1, 'h000, 0, 0, 'h140, 1, 1, 'h600, 0, 'h000, 1, 0, 'h600, 1));
        run_vec("alias_old",   mk(1, 'h100, 0, 0, 'h000, 0, 0, 'h000, 0, 'h000, 0, 0, 'h004, 1));
        run_vec("alias_new",   mk(1, 'h140, 0, 0, 'h000, 0, 0, 'h000, 1, 'h600, 0, 0, 'h004, 1));

        // randomized phase against the reference model
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        for (int c = 0; c < 800; c++) begin
            int fi, di, ctr;
            bit e_ptf, e_mis, hit;
            logic [31:0] e_tgt, e_redir;
            v.rst_n = ($urandom_range(0, 59) != 0);
            v.pcf   = pick_pc();
            v.pcd   = pick_pc();
            v.stall = ($urandom_range(0, 3) == 0);
            v.flush = ($urandom_range(0, 7) == 0);
            v.br    = 1'($urandom_range(0, 1));
            v.tk    = 1'($urandom_range(0, 1));
            v.tgt   = $urandom & 32'hFFFF_FFFC;
            drive(v);
            #2;
            fi      = int'((v.pcf >> 2) % 16);
            di      = int'((v.pcd >> 2) % 16);
            e_ptf   = m_valid[fi] && m_tag[fi] == int'((v.pcf >> 6) % 256) && m_ctr[fi] >= 2;
            e_tgt   = e_ptf ? m_tgt[fi] : 32'd0;
            e_mis   = v.br && (v.tk != m_pred);
            e_redir = v.tk ? v.tgt : v.pcd + 4;
            chk($sformatf("rnd%0d PredictTakenF", c),    32'(bp.PredictTakenF),   32'(e_ptf));
            chk($sformatf("rnd%0d PredictedTargetF", c), bp.PredictedTargetF,     e_tgt);
            chk($sformatf("rnd%0d PredictionD", c),      32'(bp.PredictionD),     32'(m_pred));
            chk($sformatf("rnd%0d MispredictD", c),      32'(bp.MispredictD),     32'(e_mis));
            chk($sformatf("rnd%0d RedirectPCD", c),      bp.RedirectPCD,          e_redir);
            chk($sformatf("rnd%0d MispredictCount", c),  32'(bp.MispredictCount), 32'(m_cnt));
            if (!v.rst_n) begin
                m_reset();
            end else begin
                if (v.br && !v.stall) begin
                    hit = m_valid[di] && m_tag[di] == int'((v.pcd >> 6) % 256);
                    if (e_mis && m_cnt < 65535) m_cnt++;
                    if (hit) begin
                        ctr = v.tk ? m_ctr[di] + 1 : m_ctr[di] - 1;
                        m_ctr[di] = (ctr > 3) ? 3 : (ctr < 0) ? 0 : ctr;
                        if (v.tk) m_tgt[di] = v.tgt;
                    end else if (v.tk) begin
                        m_valid[di] = 1;
                        m_tag[di]   = int'((v.pcd >> 6) % 256);
                        m_tgt[di]   = v.tgt;
                        m_ctr[di]   = 2;
                    end
                end
                m_pred = v.flush ? 0 : v.stall ? m_pred : e_ptf;
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor sitting between the Fetch and Decode stages of the 5-stage pipeline. It looks up the current fetch PC in a direct-mapped branch target buffer (BTB) of 2-bit saturating counters and drives a taken/not-taken prediction and target to the PC mux. It carries the prediction into Decode as `PredictionD`, which is the `Prediction` input of the hazard unit. When the branch resolves in Decode it updates the table and supplies the recovery PC on a mispredict.

## Interface
- `INDEX_BITS`, 4: BTB index width; 2^INDEX_BITS entries.
- `TAG_BITS`, 8: stored tag width.
- `CNT_WIDTH`, 16: mispredict performance counter width.

- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-low (0 = reset, sampled on `clk` rising edge).
- `PCF` in 32: fetch-stage PC.
- `PredictTakenF` out 1: combinational, predict taken for `PCF`.
- `PredictedTargetF` out 32: combinational, BTB target (valid when `PredictTakenF`=1, else 0).
- `StallD` in 1: hold the F→D prediction register.
- `FlushD` in 1: clear the F→D prediction register.
- `PredictionD` out 1: registered prediction of the instruction in Decode.
- `PCD` in 32: Decode-stage PC.
- `BranchD` in 1: Decode instruction is a conditional/unconditional branch.
- `BranchTakenD` in 1: resolved outcome in Decode.
- `BranchTargetD` in 32: resolved target in Decode.
- `MispredictD` out 1: combinational, `BranchD & (BranchTakenD ^ PredictionD)`.
- `RedirectPCD` out 32: combinational recovery PC: `BranchTargetD` if taken, else `PCD+4`.
- `MispredictCount` out CNT_WIDTH: saturating count of mispredicts.

## Operation
- Index = `PC[INDEX_BITS+1:2]`; tag = `PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]`.
- Entry = {valid, tag, target[31:0], ctr[1:0]}. Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup: `PredictTakenF = valid & tag match & ctr[1]`.
- Prediction register: on reset or `FlushD` → 0. `FlushD` has priority over `StallD`. Otherwise on `StallD` → hold, else ← `PredictTakenF`.
- Update occurs when `BranchD & ~StallD`. The entry is addressed by `PCD`.
  - Hit (valid, tag match): ctr increments if taken, saturating at 11, and decrements if not taken, saturating at 00. Target ← `BranchTargetD` if taken.
  - Miss and taken: allocate and overwrite. Set valid=1, tag, target, ctr=10.
  - Miss and not taken: no change.
- `MispredictCount` increments once per update cycle with `MispredictD`=1 and saturates at all-ones.
- `MispredictD` and `RedirectPCD` are pure functions of current inputs and `PredictionD`. With `BranchD`=0, `MispredictD`=0.

## Timing
- Lookup: 0 cycles (combinational from `PCF`). Prediction visible in Decode 1 cycle later as `PredictionD`.
- Update: table written at the rising edge ending the resolving Decode cycle. It is visible to lookups from the next cycle.
- Same-cycle lookup and update of the same index: lookup returns pre-update contents. No bypass.
- Stalled branch (`StallD`=1): no table update and no counter increment. The update happens in the cycle the stall releases, exactly once.
- Reset values: all valid=0, all ctr=01, all targets/tags 0, `PredictionD`=0, `MispredictCount`=0. Combinational outputs after reset: `PredictTakenF`=0, `PredictedTargetF`=0.
- Reset asserted mid-operation: all state returns to reset values on that edge. Any pending update in that cycle is discarded.

## Structure
- Package `bp_pkg`:
  - counter encodings `BP_SNT/BP_WNT/BP_WT/BP_ST`;
  - `bp_entry_t` struct;
  - functions `bp_index(pc)` and `bp_tag(pc)`.
- Sub-module `sat_counter2`: combinational next-state of a 2-bit saturating counter. Inputs: ctr, taken. Output: next ctr. Instantiated once on the update path.
- BTB is a flop array, not an SRAM macro, because it requires reset of valid and ctr.

## Test plan
- Reset: hold `reset`=0 two cycles, then release. Expect `PredictTakenF`=0 for `PCF`=0x100, `PredictionD`=0, `MispredictCount`=0.
- First taken branch: `PCD`=0x100, `BranchD`=1, taken, target 0x200. Expect `MispredictD`=1, `RedirectPCD`=0x200. Next cycle `PCF`=0x100 gives `PredictTakenF`=1, `PredictedTargetF`=0x200.
- Saturation and hysteresis:
  - Taken 3 more times at 0x100: ctr=11.
  - Then not-taken once: expect still predicted taken (ctr=10), mispredict, `RedirectPCD`=0x104.
  - A second not-taken gives ctr=01, predict NT.
- Tag alias: after training 0x100, look up `PCF`=0x140 (same index, different tag). Expect `PredictTakenF`=0. Not-taken resolve at 0x140 leaves the 0x100 entry intact.
- Stall/flush:
  - `PredictTakenF`=1 with `StallD`=1 → `PredictionD` holds its old value and no update occurs for a `BranchD` held during stall.
  - `FlushD`=1 together with `StallD`=1 → `PredictionD`=0.
- Same-cycle read/update and reset mid-run: update index 0 while `PCF` hits index 0. Expect the old prediction that cycle and the new one next cycle. Assert `reset`=0 with a pending update. Expect all entries invalid and `MispredictCount`=0.
